// File: rtl/uart_mem_pkg.sv
// Shared definitions for the byte-serial memory access protocol.
// Used by the host-side master and by the memory-side responder.
//   READ_CMD_DEFAULT / WRITE_CMD_DEFAULT : default command byte values
//   state_t                              : 3-bit FSM state encoding
//   CMD_IDX / ADDR_IDX / DATA_IDX        : position of each byte in a frame
package uart_mem_pkg;

  localparam logic [7:0] READ_CMD_DEFAULT  = 8'h00;
  localparam logic [7:0] WRITE_CMD_DEFAULT = 8'hFF;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TX_LOAD = 3'd1,
    TX_ACK  = 3'd2,
    TX_DONE = 3'd3,
    RX_WAIT = 3'd4,
    RESP    = 3'd5
  } state_t;

  localparam logic [1:0] CMD_IDX  = 2'd0;
  localparam logic [1:0] ADDR_IDX = 2'd1;
  localparam logic [1:0] DATA_IDX = 2'd2;

  // Index of the final byte in a frame: writes carry a data byte, reads stop at the address.
  function automatic logic [1:0] last_idx(input logic wr);
    return wr ? DATA_IDX : ADDR_IDX;
  endfunction

endpackage

// File: rtl/uart_mem_master_rise_detect.sv
// Two-flop rising-edge detector.
//   clk   : system clock
//   rst_n : asynchronous active-low reset (clears history)
//   din   : level input
//   rise  : high for one cycle, one cycle after din goes 0 -> 1
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic [1:0] hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hist <= 2'b00;
    else        hist <= {hist[0], din};
  end

  assign rise = (hist == 2'b01);

endmodule

// File: rtl/uart_mem_master.sv
// Host-side initiator: converts a parallel read/write request into a UART
// byte sequence (CMD, ADDR[, DATA]) and, for reads, collects one response byte.
//   clk, rst_n                           : clock, async active-low reset
//   req_valid/req_ready/req_wr/req_addr/req_wdata : request handshake
//   rsp_valid/rsp_rdata/rsp_timeout       : one-cycle completion report
//   busy                                  : high whenever not IDLE
//   tx_ready/tx_start_trans/tx_buff       : UART transmitter interface
//   rx_ready/rx_data                      : UART receiver interface
//
// state   | meaning
// IDLE    | waiting for a request, req_ready high
// TX_LOAD | waiting for transmitter idle, then launch byte[idx]
// TX_ACK  | waiting for transmitter to drop tx_ready (byte taken)
// TX_DONE | waiting for transmitter idle again; next byte or finish
// RX_WAIT | waiting for the read response byte or timeout
// RESP    | rsp_valid pulse
module uart_mem_master
  import uart_mem_pkg::*;
#(
  parameter logic [7:0] READ_CMD       = READ_CMD_DEFAULT,
  parameter logic [7:0] WRITE_CMD      = WRITE_CMD_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         TIMEOUT_W      = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_wr,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_timeout,
  output logic       busy,
  input  logic       tx_ready,
  output logic       tx_start_trans,
  output logic [7:0] tx_buff,
  input  logic       rx_ready,
  input  logic [7:0] rx_data
);

  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  state_t               state, state_nxt;
  logic                 wr_q;
  logic [7:0]           addr_q;
  logic [7:0]           wdata_q;
  logic [1:0]           idx;
  logic [1:0]           last;
  logic [TIMEOUT_W-1:0] tmo_cnt;
  logic                 rx_rise;
  logic                 tmo_hit;
  logic                 accept;
  logic [7:0]           byte_sel;

  rise_detect u_rx_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (rx_ready),
    .rise  (rx_rise)
  );

  assign accept  = req_valid && (state == IDLE);
  assign tmo_hit = (tmo_cnt == TMO_LAST);

  always_comb begin
    byte_sel = wdata_q;
    case (idx)
      CMD_IDX:  byte_sel = wr_q ? WRITE_CMD : READ_CMD;
      ADDR_IDX: byte_sel = addr_q;
      default:  byte_sel = wdata_q;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = TX_LOAD;
      TX_LOAD: if (tx_ready) state_nxt = TX_ACK;
      TX_ACK:  if (!tx_ready) state_nxt = TX_DONE;
      TX_DONE: begin
        if (tx_ready) begin
          if (idx < last) state_nxt = TX_LOAD;
          else if (wr_q)  state_nxt = RESP;
          else            state_nxt = RX_WAIT;
        end
      end
      RX_WAIT: if (rx_rise || tmo_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    req_ready = (state == IDLE);
    busy      = (state != IDLE);
    rsp_valid = (state == RESP);
  end

  // Registered datapath: request latch, byte launch, response capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q           <= 1'b0;
      addr_q         <= 8'h00;
      wdata_q        <= 8'h00;
      idx            <= 2'd0;
      last           <= 2'd0;
      tmo_cnt        <= '0;
      tx_start_trans <= 1'b0;
      tx_buff        <= 8'h00;
      rsp_rdata      <= 8'h00;
      rsp_timeout    <= 1'b0;
    end else begin
      tx_start_trans <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            wr_q    <= req_wr;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            idx     <= CMD_IDX;
            last    <= last_idx(req_wr);
          end
        end
        TX_LOAD: begin
          if (tx_ready) begin
            tx_buff        <= byte_sel;
            tx_start_trans <= 1'b1;
          end
        end
        TX_DONE: begin
          if (tx_ready) begin
            if (idx < last) idx <= idx + 2'd1;
            else if (wr_q)  rsp_timeout <= 1'b0;
            else            tmo_cnt <= '0;
          end
        end
        RX_WAIT: begin
          tmo_cnt <= tmo_cnt + TIMEOUT_W'(1);
          // A byte arriving on the timeout cycle still counts as a response.
          if (rx_rise) begin
            rsp_rdata   <= rx_data;
            rsp_timeout <= 1'b0;
          end else if (tmo_hit) begin
            rsp_rdata   <= 8'h00;
            rsp_timeout <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_master.sv
module tb_uart_mem_master;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_wr = 1'b0;
  logic [7:0] req_addr = 8'h00;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_timeout;
  logic       busy;
  logic       tx_ready;
  logic       tx_start_trans;
  logic [7:0] tx_buff;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  uart_mem_master #(
    .READ_CMD       (8'h00),
    .WRITE_CMD      (8'hFF),
    .TIMEOUT_CYCLES (100),
    .TIMEOUT_W      (7)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_wr         (req_wr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_rdata      (rsp_rdata),
    .rsp_timeout    (rsp_timeout),
    .busy           (busy),
    .tx_ready       (tx_ready),
    .tx_start_trans (tx_start_trans),
    .tx_buff        (tx_buff),
    .rx_ready       (rx_ready),
    .rx_data        (rx_data)
  );

  // Transmitter model: 10-cycle byte time, tx_ready drops the cycle after start.
  logic tx_busy  = 1'b0;
  logic tx_stall = 1'b0;
  int   tx_cnt   = 0;
  assign tx_ready = !tx_busy && !tx_stall;

  always @(posedge clk) begin
    if (tx_cnt > 0) begin
      tx_cnt <= tx_cnt - 1;
      if (tx_cnt == 1) tx_busy <= 1'b0;
    end else if (tx_start_trans) begin
      tx_busy <= 1'b1;
      tx_cnt  <= 10;
    end
  end

  // Monitors sampled on the falling edge
  logic [7:0] tx_q[$];
  int   wide_pulses = 0;
  int   rsp_cnt     = 0;
  logic prev_start  = 1'b0;

  always @(negedge clk) begin
    if (tx_start_trans) tx_q.push_back(tx_buff);
    if (tx_start_trans && prev_start) wide_pulses++;
    prev_start = tx_start_trans;
    if (rsp_valid) rsp_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic clear_mon();
    tx_q.delete();
    wide_pulses = 0;
    rsp_cnt     = 0;
  endtask

  task automatic do_req(input logic wr, input logic [7:0] addr, input logic [7:0] wdata);
    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int n, input string tag);
    int k = 0;
    while (tx_q.size() < n && k < 2000) begin @(posedge clk); #1; k++; end
    if (k >= 2000) chk({tag, "_bytes_budget"}, tx_q.size(), n);
  endtask

  task automatic wait_tx_idle(input string tag);
    int k = 0;
    while (tx_ready && k < 200) begin @(posedge clk); #1; k++; end
    while (!tx_ready && k < 200) begin @(posedge clk); #1; k++; end
    if (k >= 200) chk({tag, "_txidle_budget"}, 0, 1);
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin @(posedge clk); #1; n++; end while (!rsp_valid && n < 3000);
  endtask

  task automatic rx_pulse(input logic [7:0] d, input int hi);
    rx_data = d; rx_ready = 1'b1;
    repeat (hi) @(posedge clk);
    #1 rx_ready = 1'b0;
  endtask

  int n;
  int lat;

  initial begin
    // Reset state
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_tx_start", tx_start_trans, 0);
    chk("rst_tx_buff", tx_buff, 8'h00);
    chk("rst_rdata", rsp_rdata, 8'h00);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Write 0x3C <- 0xA5
    clear_mon();
    do_req(1'b1, 8'h3C, 8'hA5);
    lat = 1;
    while (!tx_start_trans && lat < 50) begin @(posedge clk); #1; lat++; end
    chk("wr_accept_to_start", lat, 2);
    wait_rsp(n);
    chk("wr_rsp_seen", rsp_valid, 1);
    chk("wr_rsp_timeout", rsp_timeout, 0);
    chk("wr_busy_at_rsp", busy, 1);
    @(posedge clk); #1;
    chk("wr_busy_after", busy, 0);
    chk("wr_rsp_after", rsp_valid, 0);
    chk("wr_nbytes", tx_q.size(), 3);
    chk("wr_b0", tx_q[0], 8'hFF);
    chk("wr_b1", tx_q[1], 8'h3C);
    chk("wr_b2", tx_q[2], 8'hA5);
    chk("wr_pulse_width", wide_pulses, 0);
    chk("wr_rsp_count", rsp_cnt, 1);

    // Read 0x12, response 0x7E 50 cycles after the address byte completes
    repeat (3) @(posedge clk);
    clear_mon();
    do_req(1'b0, 8'h12, 8'hEE);
    wait_bytes(2, "rd");
    wait_tx_idle("rd");
    repeat (50) @(posedge clk);
    #1 rx_data = 8'h7E; rx_ready = 1'b1;
    wait_rsp(n);
    chk("rd_rsp_latency", n, 2);
    chk("rd_rdata", rsp_rdata, 8'h7E);
    chk("rd_timeout", rsp_timeout, 0);
    chk("rd_nbytes", tx_q.size(), 2);
    chk("rd_b0", tx_q[0], 8'h00);
    chk("rd_b1", tx_q[1], 8'h12);
    rx_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rd_rsp_count", rsp_cnt, 1);

    // Read with no response: timeout after 100 cycles in RX_WAIT
    clear_mon();
    do_req(1'b0, 8'h20, 8'h00);
    wait_bytes(2, "to");
    wait_tx_idle("to");
    // tx_ready rose after the last edge; RX_WAIT is entered on the next edge
    wait_rsp(n);
    chk("to_latency", n, 101);
    chk("to_timeout", rsp_timeout, 1);
    chk("to_rdata", rsp_rdata, 8'h00);
    @(posedge clk); #1;
    rx_pulse(8'h66, 3);
    repeat (20) @(posedge clk); #1;
    chk("to_late_byte_ignored", rsp_cnt, 1);
    chk("to_idle_after", busy, 0);

    // Unsolicited byte during TX_ACK/TX_DONE is discarded
    clear_mon();
    do_req(1'b0, 8'h44, 8'h00);
    wait_bytes(1, "un");
    @(posedge clk); #1;
    rx_pulse(8'h55, 3);
    wait_bytes(2, "un");
    wait_tx_idle("un");
    repeat (5) @(posedge clk); #1;
    chk("un_no_early_rsp", rsp_cnt, 0);
    rx_data = 8'h99; rx_ready = 1'b1;
    wait_rsp(n);
    chk("un_rdata", rsp_rdata, 8'h99);
    chk("un_latency", n, 2);
    rx_ready = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("un_rsp_count", rsp_cnt, 1);

    // req_valid held while busy, transmitter stalled 30 cycles
    clear_mon();
    tx_stall = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 8'h5A; req_wdata = 8'hC3;
    @(posedge clk); #1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      if (req_ready) n++;
      @(posedge clk); #1;
    end
    chk("hold_req_ready_low", n, 0);
    chk("hold_busy", busy, 1);
    chk("stall_no_start", tx_q.size(), 0);
    req_valid = 1'b0;
    tx_stall  = 1'b0;
    wait_rsp(n);
    chk("stall_rsp", rsp_valid, 1);
    repeat (3) @(posedge clk); #1;
    chk("stall_nbytes", tx_q.size(), 3);
    chk("stall_b1", tx_q[1], 8'h5A);
    chk("stall_b2", tx_q[2], 8'hC3);
    chk("stall_rsp_count", rsp_cnt, 1);

    // Reset asserted in TX_ACK of a write
    repeat (15) @(posedge clk);
    clear_mon();
    do_req(1'b1, 8'h77, 8'h88);
    n = 0;
    while (!tx_start_trans && n < 50) begin @(negedge clk); n++; end
    #1 rst_n = 1'b0;
    #1;
    chk("rstx_start_cleared", tx_start_trans, 0);
    chk("rstx_busy", busy, 0);
    chk("rstx_req_ready", req_ready, 1);
    chk("rstx_tx_buff", tx_buff, 8'h00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk); #1;
    chk("rstx_no_rsp", rsp_cnt, 0);

    // Normal read after reset release
    clear_mon();
    do_req(1'b0, 8'h31, 8'h00);
    wait_bytes(2, "pr");
    wait_tx_idle("pr");
    repeat (10) @(posedge clk);
    #1 rx_data = 8'h3A; rx_ready = 1'b1;
    wait_rsp(n);
    chk("pr_rdata", rsp_rdata, 8'h3A);
    chk("pr_timeout", rsp_timeout, 0);
    chk("pr_b0", tx_q[0], 8'h00);
    chk("pr_b1", tx_q[1], 8'h31);
    rx_ready = 1'b0;
    repeat (3) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
